// File: rtl/rom_rdr_pkg.sv
// rom_rdr_pkg: shared state encoding and default geometry for the serial ROM reader
package rom_rdr_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_LAT    = 1;
endpackage

// File: rtl/serial_shift_in.sv
// serial_shift_in: LSB-first deserialiser; q updates only when the final bit of a word lands
module serial_shift_in #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] q,
  output logic         done
);
  localparam int NW = $clog2(W + 1);
  logic [W-1:0]  sr;
  logic [W-1:0]  nxt;
  logic [NW-1:0] n;
  assign nxt  = {din, sr[W-1:1]};
  assign done = en && n == NW'(W - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
      n  <= '0;
      q  <= '0;
    end else if (clr) begin
      sr <= '0;
      n  <= '0;
    end else if (en) begin
      sr <= nxt;
      n  <= done ? '0 : n + 1'b1;
      if (done) q <= nxt;
    end
  end
endmodule

// File: rtl/rom_serial_reader.sv
// rom_serial_reader: reads serial-address ROM words into parallel words with valid/ready
// Optional SERIAL_RDR_BURST_EN adds burst_len for multi-word consecutive-address reads.
module rom_serial_reader
  import rom_rdr_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LAT    = DEF_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
`ifdef SERIAL_RDR_BURST_EN
  input  logic [ADDR_W-1:0] burst_len,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_cs,
  output logic              rom_start,
  input  logic              rom_ser_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy
);
  localparam int CW = $clog2(DATA_W + LAT + 1);
  localparam logic [CW-1:0] FIRST  = CW'(LAT);
  localparam logic [CW-1:0] CS_END = CW'(DATA_W - 1);
  state_t        state;
  logic [CW-1:0] cnt;
  logic          more;
  logic          start_shift;
  logic          sample;
  logic          sh_done;
`ifdef SERIAL_RDR_BURST_EN
  logic [ADDR_W-1:0] rem;
  assign more = rem != '0;
`else
  assign more = 1'b0;
`endif
  assign req_ready   = state == IDLE;
  assign busy        = state != IDLE;
  assign start_shift = (state == IDLE && req_valid) || (state == HOLD && out_ready && more);
  // counter value c at an edge means this is edge c+1 after the ROM was enabled
  assign sample      = state == SHIFT && cnt >= FIRST;
  serial_shift_in #(.W(DATA_W)) u_shift (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_shift),
    .en   (sample),
    .din  (rom_ser_in),
    .q    (out_data),
    .done (sh_done)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rom_addr  <= '0;
      rom_cs    <= 1'b0;
      rom_start <= 1'b0;
      out_valid <= 1'b0;
      out_addr  <= '0;
`ifdef SERIAL_RDR_BURST_EN
      rem       <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          rom_addr  <= req_addr;
          rom_cs    <= 1'b1;
          rom_start <= 1'b1;
          cnt       <= '0;
          state     <= SHIFT;
`ifdef SERIAL_RDR_BURST_EN
          rem       <= burst_len;
`endif
        end
        SHIFT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CS_END) begin
            rom_cs    <= 1'b0;
            rom_start <= 1'b0;
          end
          if (sh_done) begin
            out_valid <= 1'b1;
            out_addr  <= rom_addr;
            state     <= HOLD;
          end
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          if (more) begin
            rom_addr  <= rom_addr + 1'b1;
            rom_cs    <= 1'b1;
            rom_start <= 1'b1;
            cnt       <= '0;
            state     <= SHIFT;
`ifdef SERIAL_RDR_BURST_EN
            rem       <= rem - 1'b1;
`endif
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rom_serial_reader.sv
// tb_rom_serial_reader: scoreboard bench with a registered serial ROM model (mem[i]=i, LAT=1)
module tb_rom_serial_reader;
  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_addr;
  logic [3:0] rom_addr;
  logic       rom_cs;
  logic       rom_start;
  logic       rom_ser_in;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [3:0] out_addr;
  logic       busy;
`ifdef SERIAL_RDR_BURST_EN
  logic [3:0] burst_len = 4'd0;
`endif
  logic [3:0] mem [16];
  logic [1:0] rb;
  logic [7:0] sb [$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rom_serial_reader dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
`ifdef SERIAL_RDR_BURST_EN
    .burst_len (burst_len),
`endif
    .rom_addr  (rom_addr),
    .rom_cs    (rom_cs),
    .rom_start (rom_start),
    .rom_ser_in(rom_ser_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .busy      (busy)
  );

  // ROM: restarts at bit 0 whenever enabled after an idle cycle, floats when disabled
  always @(posedge clk) begin
    if (rom_cs && rom_start) begin
      rom_ser_in <= mem[rom_addr][rb];
      rb <= rb + 2'd1;
    end else begin
      rom_ser_in <= 1'bz;
      rb <= 2'd0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) check("sb_unexpected_word", {out_addr, out_data}, 8'hxx);
      else begin
        logic [7:0] e;
        e = sb.pop_front();
        check("sb_addr", out_addr, e[7:4]);
        check("sb_data", out_data, e[3:0]);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle;
    int n = 0;
    while ((busy || out_valid) && n < 60) begin
      tick();
      n++;
    end
    check("idle_timeout", n < 60, 1);
  endtask

  task automatic request(input logic [3:0] a);
    sb.push_back({a, 4'(a)});
    req_addr  = a;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'(i);
    rst = 1'b1; req_valid = 1'b0; req_addr = 4'd0; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_req_ready", req_ready, 1);
    check("rst_cs", rom_cs, 0);
    check("rst_start", rom_start, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // single read, consumer always ready
    out_ready = 1'b1;
    request(4'd5);
    check("t2_cs_e0", rom_cs, 1);
    check("t2_start_e0", rom_start, 1);
    check("t2_rom_addr", rom_addr, 5);
    check("t2_req_ready", req_ready, 0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("t2_cs_e%0d", k), rom_cs, k < 4);
      check($sformatf("t2_valid_e%0d", k), out_valid, k == 5);
    end
    check("t2_busy_end", busy, 0);
    check("t2_ready_end", req_ready, 1);

    // stalled consumer, a second request waits for the handshake
    out_ready = 1'b0;
    request(4'd10);
    req_addr = 4'd3;
    req_valid = 1'b1;
    repeat (5) tick();
    check("t3_valid", out_valid, 1);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("t3_hold_data", out_data, 4'hA);
      check("t3_hold_addr", out_addr, 4'd10);
      check("t3_req_ready", req_ready, 0);
      check("t3_cs", rom_cs, 0);
    end
    sb.push_back(8'h33);
    out_ready = 1'b1;
    tick();
    check("t3_idle_gap", req_ready, 1);
    check("t3_idle_valid", out_valid, 0);
    tick();
    req_valid = 1'b0;
    check("t3_second_acc", rom_addr, 3);
    check("t3_second_busy", busy, 1);
    wait_idle();

    // reset mid-shift aborts the read
    req_addr = 4'd7;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_cs", rom_cs, 0);
    check("t4_start", rom_start, 0);
    check("t4_busy", busy, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t4_no_valid", out_valid, 0);
    end
    request(4'd3);
    wait_idle();

    // back-to-back reads with the ROM floating between words
    request(4'hF);
    wait_idle();
    request(4'h0);
    wait_idle();
    check("t5_out_data", out_data, 4'h0);

`ifdef SERIAL_RDR_BURST_EN
    burst_len = 4'd3;
    sb.push_back(8'hEE);
    sb.push_back(8'hFF);
    sb.push_back(8'h00);
    sb.push_back(8'h11);
    req_addr = 4'd14;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int n = 0; n < 60 && busy; n++) begin
      check("t6_req_ready", req_ready, 0);
      tick();
    end
    wait_idle();
    burst_len = 4'd0;
`endif

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
